// File: rtl/wave_gen_dds.sv
// Phase-accumulator (DDS) waveform generator: eight wave shapes, duty and amplitude
// control, configuration latched only at period boundaries, two-stage registered output.
module wave_gen_dds #(
  parameter int          OUT_W     = 8,
  parameter int          ACC_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [ACC_W-1:0] ftw,
  input  logic [OUT_W-1:0] duty,
  input  logic [OUT_W-1:0] amp,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             wrap,
  output logic             state_dbg
);

  localparam int              PW         = 2 * OUT_W + 1;
  localparam logic [OUT_W-1:0] M          = '1;
  localparam logic [OUT_W-1:0] STAIR_MASK = {OUT_W{1'b1}} << (OUT_W - 4);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_next;

  logic [ACC_W-1:0] acc, acc_sum;
  logic             carry;
  logic [OUT_W-1:0] stage1, wave, tri_t, p;
  logic             stage1_valid;
  logic [15:0]      lfsr, lfsr_next;
  logic [PW-1:0]    prod;

  logic [2:0]       sel_a;
  logic [ACC_W-1:0] ftw_a;
  logic [OUT_W-1:0] duty_a, amp_a;

  logic step, load_shadow;

  assign state_dbg = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Shadows track the inputs while idle; once running they only reload on a carry
  // (or every step when ftw_a is zero, so a stalled generator can be retuned).
  always_comb begin
    state_next  = state;
    step        = 1'b0;
    load_shadow = 1'b0;
    case (state)
      IDLE: begin
        load_shadow = 1'b1;
        if (en) state_next = RUN;
      end
      RUN: begin
        step        = en;
        load_shadow = en && (carry || (ftw_a == '0));
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    {carry, acc_sum} = {1'b0, acc} + {1'b0, ftw_a};
    p         = acc[ACC_W-1 -: OUT_W];
    tri_t     = {p[OUT_W-2:0], 1'b0};
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    prod      = PW'(stage1) * (PW'(amp_a) + PW'(1));
    wave      = '0;
    case (sel_a)
      3'd0: wave = p[OUT_W-1] ? '0 : M;
      3'd1: wave = p;
      3'd2: wave = M - p;
      3'd3: wave = p[OUT_W-1] ? (M - tri_t) : tri_t;
      3'd4: wave = (p < duty_a) ? M : '0;
      3'd5: wave = lfsr[OUT_W-1:0];
      3'd6: wave = p & STAIR_MASK;
      3'd7: wave = duty_a;
      default: wave = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      stage1       <= '0;
      stage1_valid <= 1'b0;
      out          <= '0;
      out_valid    <= 1'b0;
      wrap         <= 1'b0;
      lfsr         <= LFSR_SEED;
      sel_a        <= '0;
      ftw_a        <= '0;
      duty_a       <= '0;
      amp_a        <= '0;
    end else begin
      wrap <= 1'b0;
      if (load_shadow) begin
        sel_a  <= sel;
        ftw_a  <= ftw;
        duty_a <= duty;
        amp_a  <= amp;
      end
      if (step) begin
        acc          <= acc_sum;
        stage1       <= wave;
        stage1_valid <= 1'b1;
        out          <= OUT_W'(prod >> OUT_W);
        out_valid    <= stage1_valid;
        wrap         <= carry;
        if (carry) lfsr <= lfsr_next;
      end
    end
  end

endmodule

// File: tb/tb_wave_gen_dds.sv
// Directed bench for wave_gen_dds at OUT_W=8, ACC_W=16: ramps, triangle, square, pulse,
// boundary-latched reconfiguration, amplitude scaling, enable hold, reset and noise.
module tb_wave_gen_dds;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [2:0]  sel;
  logic [15:0] ftw;
  logic [7:0]  duty, amp;
  logic [7:0]  out;
  logic        out_valid, wrap, state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  wave_gen_dds #(.OUT_W(8), .ACC_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .ftw(ftw), .duty(duty), .amp(amp),
    .out(out), .out_valid(out_valid), .wrap(wrap), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves out holding sample 0 of the first period (edge E2 after en).
  task automatic start_run(input logic [2:0] s, input logic [15:0] f,
                           input logic [7:0] d, input logic [7:0] a);
    rst = 1'b1; en = 1'b0; sel = s; ftw = f; duty = d; amp = a;
    tick;
    rst = 1'b0; en = 1'b1;
    tick;
    check("e0_valid", out_valid, 0);
    tick;
    check("e1_valid", out_valid, 0);
    tick;
    check("e2_valid", out_valid, 1);
  endtask

  initial begin
    int hi;
    rst = 1'b1; en = 1'b0; sel = 3'd0; ftw = '0; duty = '0; amp = '0;
    tick;
    tick;
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_wrap", wrap, 0);
    check("rst_state", state_dbg, 0);

    // saw up, full amplitude
    start_run(3'd1, 16'd256, 8'd0, 8'd255);
    for (int n = 0; n < 300; n++) begin
      check("saw_out", out, n % 256);
      check("saw_wrap", wrap, (n % 256) == 254);
      tick;
    end

    // triangle
    start_run(3'd3, 16'd256, 8'd0, 8'd255);
    for (int n = 0; n < 300; n++) begin
      int m;
      m = n % 256;
      check("tri_out", out, (m < 128) ? 2 * m : 511 - 2 * m);
      tick;
    end

    // square
    start_run(3'd0, 16'd256, 8'd0, 8'd255);
    for (int n = 0; n < 300; n++) begin
      check("sq_out", out, ((n % 256) < 128) ? 255 : 0);
      tick;
    end

    // pulse, duty 64 then duty 0
    start_run(3'd4, 16'd256, 8'd64, 8'd255);
    hi = 0;
    for (int n = 0; n < 256; n++) begin
      check("pulse_out", out, (n < 64) ? 255 : 0);
      if (out == 8'd255) hi++;
      tick;
    end
    check("pulse_count", hi, 64);
    start_run(3'd4, 16'd256, 8'd0, 8'd255);
    hi = 0;
    for (int n = 0; n < 256; n++) begin
      if (out != 8'd0) hi++;
      tick;
    end
    check("pulse0_count", hi, 0);

    // mid-period retune: takes effect only after the next wrap
    start_run(3'd1, 16'd256, 8'd0, 8'd255);
    for (int n = 0; n < 520; n++) begin
      check("retune_out", out, (n <= 255) ? n : 255 - 2 * ((n - 256) % 128));
      check("retune_wrap", wrap, (n == 254) || (n >= 382 && ((n - 382) % 128) == 0));
      if (n == 100) begin
        sel = 3'd2;
        ftw = 16'd512;
      end
      tick;
    end

    // amplitude 127: half scale
    start_run(3'd1, 16'd256, 8'd0, 8'd127);
    for (int n = 0; n < 256; n++) exp_q.push_back(8'(n >> 1));
    while (exp_q.size() > 0) begin
      check("amp127_out", out, exp_q.pop_front());
      tick;
    end
    start_run(3'd1, 16'd256, 8'd0, 8'd0);
    hi = 0;
    for (int n = 0; n < 256; n++) begin
      if (out != 8'd0) hi++;
      tick;
    end
    check("amp0_count", hi, 0);

    // enable hold, then reset mid-run
    start_run(3'd1, 16'd256, 8'd0, 8'd255);
    for (int n = 0; n < 50; n++) tick;
    check("hold_pre", out, 50);
    en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick;
      check("hold_out", out, 50);
      check("hold_valid", out_valid, 1);
      check("hold_wrap", wrap, 0);
    end
    en = 1'b1;
    tick;
    check("resume_out", out, 51);
    tick;
    check("resume_out2", out, 52);
    rst = 1'b1;
    tick;
    check("midrst_out", out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_state", state_dbg, 0);
    rst = 1'b0; en = 1'b0;
    tick;
    check("idle_state", state_dbg, 0);

    // noise: seed low byte, then one LFSR step after the first wrap
    start_run(3'd5, 16'd256, 8'd0, 8'd255);
    for (int n = 0; n < 300; n++) begin
      check("noise_out", out, (n <= 255) ? 8'hE1 : 8'hC3);
      check("noise_wrap", wrap, n == 254);
      tick;
    end

    // ftw=0: DC retunes every step, then restart as a ramp without reset
    start_run(3'd7, 16'd0, 8'h5A, 8'd255);
    check("dc_out", out, 8'h5A);
    duty = 8'h33;
    tick;
    tick;
    check("dc_lag", out, 8'h5A);
    tick;
    check("dc_new", out, 8'h33);
    check("dc_wrap", wrap, 0);
    sel = 3'd1;
    ftw = 16'd256;
    tick;
    tick;
    tick;
    check("restart_out0", out, 0);
    tick;
    check("restart_out1", out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_gen_dds.md
Name: wave_gen_dds

Overview:
- Parametrised successor to the fixed 8-bit, 3-bit-select waveform generator.
- Replaces the fixed-period counter with a phase accumulator, so output frequency is set by a tuning word (DDS).
- Adds eight waveform modes, duty control, amplitude scaling, glitch-free configuration updates at period boundaries, and a 2-stage output pipeline with a valid flag.
- Drives the lab DAC/scope path from the system clock.

Parameters:
- OUT_W, 8: output sample width. Legal range 4..16.
- ACC_W, 16: phase accumulator width. Must be >= OUT_W.
- LFSR_SEED, 16'hACE1: reset value of the noise LFSR. Must be non-zero.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  run/advance enable.
- sel  in  3  waveform select; shadowed.
- ftw  in  ACC_W  frequency tuning word; shadowed.
- duty  in  OUT_W  pulse threshold / DC level; shadowed.
- amp  in  OUT_W  amplitude scale; shadowed.
- out  out  OUT_W  scaled sample, registered.
- out_valid  out  1  out holds a valid sample.
- wrap  out  1  one-cycle pulse on accumulator carry.

Behaviour:
- Reset, synchronous, dominates all other inputs:
  - acc=0, state=IDLE, out=0, out_valid=0, wrap=0.
  - stage1=0, lfsr=LFSR_SEED, all shadow regs=0.
  - Reset asserted mid-run takes effect on the next edge with these same values.
- FSM has two states, IDLE and RUN.
- IDLE:
  - Shadow regs (sel_a, ftw_a, duty_a, amp_a) load from the inputs every cycle.
  - acc is held at 0.
  - en=1 moves the FSM to RUN on that edge; acc stays 0 on that edge.
- RUN with en=1, on each edge:
  - stage1 <= wave(p), where p = acc[ACC_W-1 -: OUT_W].
  - acc <= (acc + ftw_a) mod 2^ACC_W.
  - out <= (stage1 * (amp_a+1)) >> OUT_W. The product is OUT_W x (OUT_W+1) bits wide.
  - out_valid sets once stage1 holds a sample. It is high from the 2nd RUN+en edge onward.
- RUN with en=0: acc, stage1, out, out_valid and lfsr all hold; wrap=0. No return to IDLE except via rst.
- Latency: the sample for acc value A appears on out 2 enabled edges after A is present in acc.
- Sequence after en rises in IDLE:
  - Edge E0: enter RUN.
  - Edge E1: stage1=wave(0).
  - Edge E2: out=scaled wave(0), out_valid=1.
- Wrap:
  - When acc+ftw_a carries out of ACC_W on an enabled RUN edge, wrap=1 for that cycle (registered). Otherwise wrap=0.
  - On that same edge the shadow regs reload from the inputs; lfsr advances one step.
  - The add on the carry edge itself uses the old ftw_a.
  - Input changes mid-period have no effect until the next wrap. This guarantees no partial periods.
- ftw_a==0 in RUN: the shadow regs reload every enabled edge, so the generator is restartable without reset.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift-left, feedback into bit 0.
- Waveform function wave(p), with M = 2^OUT_W-1:
  - 0 square: p[MSB] ? 0 : M.
  - 1 saw up: p.
  - 2 saw down: M-p.
  - 3 triangle: t = {p[OUT_W-2:0],1'b0}; output p[MSB] ? M-t : t.
  - 4 pulse: (p < duty_a) ? M : 0. duty_a=0 gives always 0.
  - 5 noise: lfsr[OUT_W-1:0].
  - 6 staircase: {p[MSB -: 4], zeros}, i.e. 16 steps.
  - 7 DC: duty_a, independent of p.
- Amplitude boundaries: amp=M passes stage1 unchanged; amp=0 gives out=0.
- All arithmetic is unsigned. No saturation is needed: the scaled result is always <= stage1.

Test Plan:
1. Reset, then en=1, sel=1, ftw=256, amp=255 (OUT_W=8, ACC_W=16).
   -> out_valid rises 2 edges after entering RUN.
   -> out = 0,1,2,…,255,0 on consecutive cycles.
   -> wrap pulses every 256 cycles.
2. Triangle, sel=3, ftw=256.
   -> out = 0,2,4,…,254,255,253,…,1 per period.
   -> Square, sel=0: 128 cycles of 255 then 128 cycles of 0.
3. Pulse, sel=4, duty=64, ftw=256.
   -> exactly 64 samples of 255, then 192 of 0, per period.
   -> duty=0: all samples 0.
4. Saw running at ftw=256; change sel to 2 and ftw to 512 mid-period.
   -> output continues up-ramp until wrap.
   -> Next period is a down-ramp 255,253,…, with wrap every 128 cycles.
5. amp=127 with saw.
   -> sample 255 gives out=127; sample 100 gives out=50.
   -> amp=0: out=0 throughout.
6. Drop en for 10 cycles mid-ramp.
   -> out, out_valid, acc frozen; wrap=0; resumes with next value.
   -> rst mid-run: next edge gives out=0, out_valid=0, state IDLE.
   -> Noise, sel=5: first post-reset wrap gives lfsr=16'h59C3, out=8'hC3.
